reg_file_seq: RTL and testbench

- Micro-op sequencer that owns every port of the 8x16 `reg_file`: the write port and both read ports.
- Accepts one ALU micro-op at a time through a valid/ready handshake. For each op it reads two source registers, computes a result and writes it back to a destination register.
- Also arbitrates the single write port against an external loader port used for initialisation and debug.
- Sits between the instruction front-end and `reg_file`.

---
 rtl/reg_file_seq_pkg.sv | 35 +++
 rtl/reg_file_seq_alu.sv | 40 ++++
 rtl/reg_file_seq.sv | 148 ++++++++++++++
 tb/tb_reg_file_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared constants and types for the reg_file micro-op sequencer.
package reg_file_seq_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned CODE_W = 3;

   typedef enum logic [CODE_W-1:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_MOV = 3'd6,
      OP_LDI = 3'd7
   } op_code_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   // Micro-op as latched at the accept handshake
   typedef struct packed {
      op_code_e            code;
      logic [ADDR_W-1:0]   rd;
      logic [ADDR_W-1:0]   rs1;
      logic [ADDR_W-1:0]   rs2;
      logic [DATA_W-1:0]   imm;
   } uop_t;

endpackage

// File: rtl/reg_file_seq_alu.sv
// Combinational ALU for the sequencer: (code, A, B, imm) -> (result, carry/borrow).
module seq_alu
   import reg_file_seq_pkg::*;
(
   input  op_code_e          code,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // Zero-extended operands make bit DATA_W the carry (ADD) or borrow (SUB)
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = '0;
      carry  = 1'b0;
      case (code)
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         OP_SUB: begin
            result = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_MOV:  result = a;
         OP_LDI:  result = imm;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/reg_file_seq.sv
// Micro-op sequencer owning all reg_file ports; IDLE->READ->EXEC->WRITE with loader arbitration.
// Optional REG_ZERO_HARDWIRE_EN: r0 reads as zero and writes to r0 are suppressed.
module reg_file_seq
   import reg_file_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [CODE_W-1:0] op_code,
   input  logic [ADDR_W-1:0] op_rd,
   input  logic [ADDR_W-1:0] op_rs1,
   input  logic [ADDR_W-1:0] op_rs2,
   input  logic [DATA_W-1:0] op_imm,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              rf_wr,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_d_in,
   output logic [ADDR_W-1:0] rf_rd_addr_a,
   output logic [ADDR_W-1:0] rf_rd_addr_b,
   input  logic [DATA_W-1:0] rf_d_out_a,
   input  logic [DATA_W-1:0] rf_d_out_b,
   output logic              done,
   output logic              flag_z,
   output logic              flag_c
);

   state_e            state;
   state_e            state_nxt;
   uop_t              uop;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] res;
   logic              res_c;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              wr_req;

`ifdef REG_ZERO_HARDWIRE_EN
   assign rd_a  = (uop.rs1 == '0) ? '0 : rf_d_out_a;
   assign rd_b  = (uop.rs2 == '0) ? '0 : rf_d_out_b;
   assign rf_wr = wr_req && (rf_wr_addr != '0);
`else
   assign rd_a  = rf_d_out_a;
   assign rd_b  = rf_d_out_b;
   assign rf_wr = wr_req;
`endif

   seq_alu u_alu (
      .code   (uop.code),
      .a      (opa),
      .b      (opb),
      .imm    (uop.imm),
      .result (alu_res),
      .carry  (alu_carry)
   );

   // State register plus the datapath registers loaded in each phase
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         uop    <= '0;
         opa    <= '0;
         opb    <= '0;
         res    <= '0;
         res_c  <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (op_valid && op_ready) begin
                  uop <= '{code: op_code_e'(op_code), rd: op_rd, rs1: op_rs1,
                           rs2: op_rs2, imm: op_imm};
               end
            end
            ST_READ: begin
               opa <= rd_a;
               opb <= rd_b;
            end
            ST_EXEC: begin
               res   <= alu_res;
               res_c <= alu_carry;
            end
            ST_WRITE: begin
               if (uop.code != OP_NOP) begin
                  flag_z <= (res == '0);
                  flag_c <= res_c;
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and handshake/port drive; loader wins over op_valid in IDLE
   always_comb begin
      state_nxt    = state;
      op_ready     = 1'b0;
      ld_ready     = 1'b0;
      done         = 1'b0;
      wr_req       = 1'b0;
      rf_wr_addr   = '0;
      rf_d_in      = '0;
      rf_rd_addr_a = '0;
      rf_rd_addr_b = '0;
      case (state)
         ST_IDLE: begin
            if (ld_valid) begin
               ld_ready   = 1'b1;
               wr_req     = 1'b1;
               rf_wr_addr = ld_addr;
               rf_d_in    = ld_data;
            end else begin
               op_ready = 1'b1;
               if (op_valid) begin
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ: begin
            rf_rd_addr_a = uop.rs1;
            rf_rd_addr_b = uop.rs2;
            state_nxt    = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            done = 1'b1;
            if (uop.code != OP_NOP) begin
               wr_req     = 1'b1;
               rf_wr_addr = uop.rd;
               rf_d_in    = res;
            end
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_file_seq.sv
// Self-checking bench for reg_file_seq: behavioural register/flag model, directed steps then random ops.
module tb_reg_file_seq;

`ifdef REG_ZERO_HARDWIRE_EN
   localparam bit HW = 1'b1;
`else
   localparam bit HW = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [2:0]  op_rd;
   logic [2:0]  op_rs1;
   logic [2:0]  op_rs2;
   logic [15:0] op_imm;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic        rf_wr;
   logic [2:0]  rf_wr_addr;
   logic [15:0] rf_d_in;
   logic [2:0]  rf_rd_addr_a;
   logic [2:0]  rf_rd_addr_b;
   logic [15:0] rf_d_out_a;
   logic [15:0] rf_d_out_b;
   logic        done;
   logic        flag_z;
   logic        flag_c;

   int n_tests = 0;
   int n_fail  = 0;

   // Environment: the 8x16 reg_file itself (plain storage, combinational reads)
   logic [15:0] rf_mem [8];
   always @(posedge clk) if (rf_wr) rf_mem[rf_wr_addr] <= rf_d_in;
   assign rf_d_out_a = rf_mem[rf_rd_addr_a];
   assign rf_d_out_b = rf_mem[rf_rd_addr_b];

   // Reference model state
   logic [15:0] exp_rf [8];
   logic        exp_z;
   logic        exp_c;

   always #5 clk = ~clk;

   reg_file_seq dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_code      (op_code),
      .op_rd        (op_rd),
      .op_rs1       (op_rs1),
      .op_rs2       (op_rs2),
      .op_imm       (op_imm),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .rf_wr        (rf_wr),
      .rf_wr_addr   (rf_wr_addr),
      .rf_d_in      (rf_d_in),
      .rf_rd_addr_a (rf_rd_addr_a),
      .rf_rd_addr_b (rf_rd_addr_b),
      .rf_d_out_a   (rf_d_out_a),
      .rf_d_out_b   (rf_d_out_b),
      .done         (done),
      .flag_z       (flag_z),
      .flag_c       (flag_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit writable(input logic [2:0] a);
      return !(HW && a == 3'd0);
   endfunction

   function automatic logic [15:0] model_rd(input logic [2:0] a);
      return writable(a) ? exp_rf[a] : 16'h0000;
   endfunction

   function automatic void model_wr(input logic [2:0] a, input logic [15:0] d);
      if (writable(a)) exp_rf[a] = d;
   endfunction

   // Architectural meaning of each op code, in plain integer arithmetic
   function automatic void model_alu(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] imm, output logic [15:0] r, output logic c);
      int s;
      c = 1'b0;
      r = 16'h0000;
      case (code)
         3'd1: begin s = int'(a) + int'(b); r = 16'(s); c = (s > 65535); end
         3'd2: begin r = a - b; c = (a < b); end
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = a;
         3'd7: r = imm;
         default: r = 16'h0000;
      endcase
   endfunction

   // Called at a negedge with the sequencer idle
   task automatic do_load(input logic [2:0] a, input logic [15:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      #1;
      chk("ld_ready", ld_ready, 1);
      chk("ld_op_ready", op_ready, 0);
      chk("ld_rf_wr", rf_wr, writable(a));
      @(posedge clk);
      model_wr(a, d);
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] code, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] imm,
                        input bit with_ld, input bit bp, input logic [2:0] la, input logic [15:0] ldd);
      logic [15:0] a, b, r, bp_d;
      logic [2:0]  bp_a;
      logic        c;
      bit          ew;
      op_valid = 1'b1; op_code = code; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2; op_imm = imm;
      if (with_ld) begin
         ld_valid = 1'b1; ld_addr = la; ld_data = ldd;
         #1;
         chk("arb_ld_ready", ld_ready, 1);
         chk("arb_op_ready", op_ready, 0);
         @(posedge clk);
         model_wr(la, ldd);
         @(negedge clk);
         ld_valid = 1'b0;
      end
      #1 chk("op_ready", op_ready, 1);
      @(posedge clk);
      a = model_rd(rs1);
      b = model_rd(rs2);
      model_alu(code, a, b, imm, r, c);
      @(negedge clk);
      op_valid = 1'b0;
      op_code = 3'($urandom); op_rd = 3'($urandom); op_rs1 = 3'($urandom);
      op_rs2 = 3'($urandom); op_imm = 16'($urandom);
      bp_a = 3'($urandom); bp_d = 16'($urandom);
      if (bp) begin ld_valid = 1'b1; ld_addr = bp_a; ld_data = bp_d; end
      #1;
      chk("read_done", done, 0);
      chk("read_rf_wr", rf_wr, 0);
      chk("read_addr_a", rf_rd_addr_a, rs1);
      chk("read_addr_b", rf_rd_addr_b, rs2);
      chk("read_ld_ready", ld_ready, 0);
      @(negedge clk); #1;
      chk("exec_done", done, 0);
      chk("exec_rf_wr", rf_wr, 0);
      chk("exec_ld_ready", ld_ready, 0);
      @(negedge clk); #1;
      ew = (code != 3'd0) && writable(rd);
      chk("write_done", done, 1);
      chk("write_rf_wr", rf_wr, ew);
      chk("write_ld_ready", ld_ready, 0);
      chk("write_op_ready", op_ready, 0);
      if (ew) begin
         chk("write_addr", rf_wr_addr, rd);
         chk("write_data", rf_d_in, r);
      end
      @(posedge clk);
      if (code != 3'd0) begin
         model_wr(rd, r);
         exp_z = (r == 16'h0000);
         exp_c = c;
      end
      @(negedge clk); #1;
      chk("after_done", done, 0);
      chk("flag_z", flag_z, exp_z);
      chk("flag_c", flag_c, exp_c);
      if (ew) chk("rf_value", rf_mem[rd], exp_rf[rd]);
      if (bp) begin
         chk("bp_ld_ready", ld_ready, 1);
         chk("bp_rf_wr", rf_wr, writable(bp_a));
         @(posedge clk);
         model_wr(bp_a, bp_d);
         @(negedge clk);
         ld_valid = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0; op_valid = 1'b0; op_code = '0; op_rd = '0; op_rs1 = '0; op_rs2 = '0;
      op_imm = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0000;
      exp_z = 1'b0; exp_c = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rf_wr", rf_wr, 0);
      chk("rst_done", done, 0);
      chk("rst_flag_z", flag_z, 0);
      chk("rst_flag_c", flag_c, 0);
      chk("rst_rd_addr_a", rf_rd_addr_a, 0);
      chk("rst_wr_addr", rf_wr_addr, 0);
      chk("rst_d_in", rf_d_in, 0);
      chk("rst_op_ready", op_ready, 1);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) do_load(3'(i), 16'($urandom));

      // Loader then ADD with carry out
      do_load(3'd1, 16'h0005);
      do_load(3'd2, 16'hFFFF);
      do_op(3'd1, 3'd3, 3'd1, 3'd2, 16'h0, 0, 0, 3'd0, 16'h0);
      chk("add_r3", rf_mem[3], 16'h0004);
      chk("add_c", flag_c, 1);
      chk("add_z", flag_z, 0);

      // Reset while an ADD sits in EXEC: op abandoned, flags cleared
      op_valid = 1'b1; op_code = 3'd1; op_rd = 3'd5; op_rs1 = 3'd1; op_rs2 = 3'd1;
      @(posedge clk);
      @(negedge clk); op_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_rf_wr0", rf_wr, 0);
      @(negedge clk); #1;
      chk("midrst_rf_wr1", rf_wr, 0);
      chk("midrst_done1", done, 0);
      @(negedge clk); #1;
      chk("midrst_rf_wr2", rf_wr, 0);
      chk("midrst_done2", done, 0);
      chk("midrst_flag_z", flag_z, 0);
      chk("midrst_flag_c", flag_c, 0);
      reset = 1'b1;
      exp_z = 1'b0; exp_c = 1'b0;
      #1 chk("midrst_op_ready", op_ready, 1);
      @(negedge clk); #1;
      chk("midrst_no_done", done, 0);
      chk("midrst_r5_kept", rf_mem[5], exp_rf[5]);

      // Subtraction cases
      do_op(3'd2, 3'd4, 3'd1, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);
      chk("sub_r4", rf_mem[4], 16'h0000);
      chk("sub_r4_z", flag_z, 1);
      chk("sub_r4_c", flag_c, 0);
      do_op(3'd2, 3'd5, 3'd2, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);
      chk("sub_r5", rf_mem[5], 16'hFFFA);
      chk("sub_r5_c", flag_c, 0);
      do_op(3'd2, 3'd6, 3'd1, 3'd2, 16'h0, 0, 0, 3'd0, 16'h0);
      chk("sub_r6", rf_mem[6], 16'h0006);
      chk("sub_r6_c", flag_c, 1);

      // Loader and op offered together: loader first, op next
      do_op(3'd7, 3'd7, 3'd0, 3'd0, 16'hABCD, 1, 0, 3'd7, 16'h1234);
      chk("arb_r7", rf_mem[7], 16'hABCD);

      // Loader held during an op, then a NOP under back-pressure
      do_op(3'd5, 3'd6, 3'd3, 3'd7, 16'h0, 0, 1, 3'd0, 16'h0);
      do_op(3'd0, 3'd2, 3'd1, 3'd1, 16'h0, 0, 1, 3'd0, 16'h0);

      // r0 load and MOV out of r0
      do_load(3'd0, 16'hBEEF);
      do_op(3'd6, 3'd1, 3'd0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
      chk("mov_r0_r1", rf_mem[1], HW ? 16'h0000 : 16'hBEEF);

      // Random mix of loads and ops
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 4) == 0) do_load(3'($urandom), 16'($urandom));
         do_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               3'($urandom), 16'($urandom));
      end

      for (int i = 0; i < 8; i++) begin
         if (writable(3'(i))) chk("final_rf", rf_mem[i], exp_rf[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
